// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Byte-stream program loader sitting on the write side of instruction memory.
// Bytes arrive from a UART-RX style valid/ready source and are parsed as a
// framed image:
//
//     SYNC_BYTE, LEN_LO, LEN_HI, then LEN little-endian 32-bit words
//
// Each completed word is written to the instruction-memory write port at
// consecutive word addresses starting from 0. The core is held in reset
// until a complete frame has been written. It is held in reset again as soon
// as the SYNC of a reload frame is accepted.
//
// Parameters
//   ADDR_WIDTH      instruction-memory word-address width (capacity 2**ADDR_WIDTH)
//   SYNC_BYTE       frame start marker
//   TIMEOUT_CYCLES  max idle cycles between bytes inside a frame
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   rx_data     in   incoming byte
//   rx_valid    in   rx_data valid
//   rx_ready    out  loader accepts byte (always 1 once out of reset)
//   imem_we     out  instruction-memory write strobe, one-cycle pulse
//   imem_addr   out  word address for the write
//   imem_wdata  out  word to write
//   core_rst    out  active-high reset to the core
//   load_done   out  image loaded, core running
//   load_err    out  last frame aborted, sticky until the next SYNC
//
// Every output is a flop. The write strobe comes one cycle after the fourth
// byte of a word is accepted.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err
);

    // Idle counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Word counter must be able to hold a full-capacity length (2**ADDR_WIDTH).
    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [16:0]   CAPACITY    = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t          state_r;
    logic [7:0]      len_lo_r;
    logic [15:0]     len_r;
    logic [CW-1:0]   word_cnt_r;
    logic [1:0]      byte_idx_r;
    logic [23:0]     shift_r;     // lanes 0..2 of the word being assembled
    logic [TW-1:0]   idle_cnt_r;

    logic            accept_s;
    logic            is_sync_s;
    logic [15:0]     len_full_s;
    logic [TW-1:0]   idle_next_s;
    logic            timeout_s;
    logic [CW-1:0]   word_next_s;
    logic            last_word_s;
    logic            len_too_big_s;

    // Decode of the incoming byte and counter look-ahead values.
    always_comb begin
        accept_s      = rx_valid & rx_ready;
        is_sync_s     = (rx_data == SYNC_BYTE);
        len_full_s    = {rx_data, len_lo_r};
        idle_next_s   = idle_cnt_r + TW'(1);
        timeout_s     = (idle_next_s == TIMEOUT_LIM);
        word_next_s   = word_cnt_r + CW'(1);
        last_word_s   = (17'(word_next_s) == {1'b0, len_r});
        len_too_big_s = ({1'b0, len_full_s} > CAPACITY);
    end

    // Frame parser FSM with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            len_lo_r   <= 8'd0;
            len_r      <= 16'd0;
            word_cnt_r <= '0;
            byte_idx_r <= 2'd0;
            shift_r    <= 24'd0;
            idle_cnt_r <= '0;
            rx_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Never back-pressure; the write strobe is a single-cycle pulse.
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;

            case (state_r)
                S_IDLE: begin
                    idle_cnt_r <= '0;
                    core_rst   <= 1'b1;
                    load_done  <= 1'b0;
                    if (accept_s && is_sync_s) begin
                        state_r  <= S_LEN_LO;
                        load_err <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;   // junk before SYNC is dropped
                    end
                end

                S_LEN_LO: begin
                    if (accept_s) begin
                        len_lo_r   <= rx_data;
                        idle_cnt_r <= '0;
                        state_r    <= S_LEN_HI;
                    end else if (timeout_s) begin
                        idle_cnt_r <= '0;
                        load_err   <= 1'b1;
                        state_r    <= S_ERR;
                    end else begin
                        idle_cnt_r <= idle_next_s;
                    end
                end

                S_LEN_HI: begin
                    if (accept_s) begin
                        len_r      <= len_full_s;
                        idle_cnt_r <= '0;
                        if (len_full_s == 16'd0) begin
                            // Empty image: release the core without writing.
                            core_rst  <= 1'b0;
                            load_done <= 1'b1;
                            state_r   <= S_DONE;
                        end else if (len_too_big_s) begin
                            load_err <= 1'b1;
                            state_r  <= S_ERR;
                        end else begin
                            word_cnt_r <= '0;
                            byte_idx_r <= 2'd0;
                            state_r    <= S_DATA;
                        end
                    end else if (timeout_s) begin
                        idle_cnt_r <= '0;
                        load_err   <= 1'b1;
                        state_r    <= S_ERR;
                    end else begin
                        idle_cnt_r <= idle_next_s;
                    end
                end

                S_DATA: begin
                    if (accept_s) begin
                        idle_cnt_r <= '0;
                        byte_idx_r <= byte_idx_r + 2'd1;   // wraps 3 -> 0
                        case (byte_idx_r)
                            2'd0: shift_r[7:0]   <= rx_data;
                            2'd1: shift_r[15:8]  <= rx_data;
                            2'd2: shift_r[23:16] <= rx_data;
                            2'd3: begin
                                // Fourth lane completes the word; write it now.
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, shift_r};
                                imem_addr  <= word_cnt_r[ADDR_WIDTH-1:0];
                                word_cnt_r <= word_next_s;
                                if (last_word_s) begin
                                    // Release the core alongside the final write.
                                    core_rst  <= 1'b0;
                                    load_done <= 1'b1;
                                    state_r   <= S_DONE;
                                end else begin
                                    state_r <= S_DATA;
                                end
                            end
                            default: shift_r <= shift_r;
                        endcase
                    end else if (timeout_s) begin
                        // Words already written remain in memory.
                        idle_cnt_r <= '0;
                        load_err   <= 1'b1;
                        state_r    <= S_ERR;
                    end else begin
                        idle_cnt_r <= idle_next_s;
                    end
                end

                S_DONE: begin
                    idle_cnt_r <= '0;
                    if (accept_s && is_sync_s) begin
                        // Reload: hold the core again while the new image lands.
                        core_rst  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        state_r   <= S_LEN_LO;
                    end else begin
                        state_r <= S_DONE;
                    end
                end

                S_ERR: begin
                    // One-cycle abort state; any byte arriving now is dropped.
                    idle_cnt_r <= '0;
                    core_rst   <= 1'b1;
                    load_done  <= 1'b0;
                    load_err   <= 1'b1;
                    state_r    <= S_IDLE;
                end

                default: begin
                    idle_cnt_r <= '0;
                    core_rst   <= 1'b1;
                    load_done  <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
